fire_ctrl_multi: RTL and testbench

- Multi-channel successor to the single-button fire trigger.
- Each channel (player cannon, alien shooters) has its own fire request and a frame-counted cooldown.
- Each channel caps its in-flight shots and selects single-shot or auto-repeat mode.
- Updates only on frame ticks (pixel 0, line 0) while the game is enabled; output feeds the bullet spawners as one-cycle fire pulses.

---
 rtl/fire_ctrl_multi_if.sv | 30 +++
 rtl/fire_ctrl_multi.sv | 107 ++++++++++
 tb/tb_fire_ctrl_multi.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fire_ctrl_multi_if.sv
// Fire controller bus: game/frame qualifiers, per-channel requests and
// bullet-death pulses in; per-channel fire pulses, cooldown flags and
// in-flight counts out.
//   enb, frame_tick       game running / frame tick (pixel 0, line 0)
//   btn, auto_mode        per-channel fire request and repeat mode
//   bullet_done           per-channel bullet-died pulse
//   fire, cooling         per-channel spawn pulse / in-cooldown flag
//   shots_live            3 bits per channel, channel i at [3i+2:3i]
interface fire_ctrl_multi_if #(
   parameter int N_CH = 4
) ();
   logic                enb;
   logic                frame_tick;
   logic [N_CH-1:0]     btn;
   logic [N_CH-1:0]     auto_mode;
   logic [N_CH-1:0]     bullet_done;
   logic [N_CH-1:0]     fire;
   logic [N_CH-1:0]     cooling;
   logic [3*N_CH-1:0]   shots_live;

   modport master (
      output enb, frame_tick, btn, auto_mode, bullet_done,
      input  fire, cooling, shots_live
   );

   modport slave (
      input  enb, frame_tick, btn, auto_mode, bullet_done,
      output fire, cooling, shots_live
   );
endinterface

// File: rtl/fire_ctrl_multi.sv
// Multi-channel fire controller. Each channel fires a one-cycle pulse on a
// frame tick when requested, then cools down for CD_FRAMES ticks. Single-shot
// channels require a release after cooldown; auto channels repeat while held.
// In-flight bullets per channel are counted and capped at MAX_SHOTS.
//   clk, rst   system clock, synchronous active-high reset
//   bus        fire_ctrl_multi_if slave (see interface header)
//
// state | meaning
// IDLE  | ready; fires on a frame tick when requested, under the cap, granted
// COOL  | cooldown after a shot, cd counts frame ticks down to 0
// HOLD  | single-shot channel waiting for the button to be released
module fire_ctrl_multi #(
   parameter int N_CH         = 4,
   parameter int CD_W         = 6,
   parameter int CD_FRAMES    = 40,
   parameter int MAX_SHOTS    = 1,
   parameter int ONE_PER_TICK = 0
) (
   input  logic                clk,
   input  logic                rst,
   fire_ctrl_multi_if.slave    bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_COOL = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   localparam logic [CD_W-1:0] CD_LOAD  = CD_W'(CD_FRAMES - 1);
   localparam logic [2:0]      SHOT_CAP = 3'(MAX_SHOTS);

   logic [N_CH-1:0][1:0]      state_q, state_nxt;
   logic [N_CH-1:0][CD_W-1:0] cd_q, cd_nxt;
   logic [N_CH-1:0][2:0]      shots_q, shots_nxt;
   logic [N_CH-1:0]           fire_q, fire_nxt;
   logic [N_CH-1:0]           elig, grant, done_ok, cooling;
   logic                      upd;

   assign upd = bus.enb & bus.frame_tick;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= '0;
         cd_q    <= '0;
         shots_q <= '0;
         fire_q  <= '0;
      end else begin
         state_q <= state_nxt;
         cd_q    <= cd_nxt;
         shots_q <= shots_nxt;
         fire_q  <= fire_nxt;
      end
   end

   always_comb begin
      elig      = '0;
      done_ok   = '0;
      state_nxt = state_q;
      cd_nxt    = cd_q;
      shots_nxt = shots_q;
      fire_nxt  = '0;
      for (int i = 0; i < N_CH; i++) begin
         elig[i] = (state_q[i] == ST_IDLE) & bus.btn[i] & (shots_q[i] < SHOT_CAP);
      end
      // lowest set bit of elig when only one channel may fire per tick
      if (ONE_PER_TICK != 0) grant = elig & (~elig + N_CH'(1));
      else                   grant = elig;
      for (int i = 0; i < N_CH; i++) begin
         if (upd) begin
            case (state_q[i])
               ST_IDLE: begin
                  if (grant[i]) begin
                     fire_nxt[i]  = 1'b1;
                     cd_nxt[i]    = CD_LOAD;
                     state_nxt[i] = ST_COOL;
                  end
               end
               ST_COOL: begin
                  if (cd_q[i] != '0)          cd_nxt[i]    = cd_q[i] - CD_W'(1);
                  else if (bus.auto_mode[i]) state_nxt[i] = ST_IDLE;
                  else if (bus.btn[i])       state_nxt[i] = ST_HOLD;
                  else                       state_nxt[i] = ST_IDLE;
               end
               ST_HOLD: begin
                  if (!bus.btn[i]) state_nxt[i] = ST_IDLE;
               end
               default: state_nxt[i] = ST_IDLE;
            endcase
         end
         // a death with nothing in flight is dropped; spawn + death cancel
         done_ok[i] = bus.enb & bus.bullet_done[i] & (shots_q[i] != 3'd0);
         if (fire_nxt[i] & ~done_ok[i])      shots_nxt[i] = shots_q[i] + 3'd1;
         else if (done_ok[i] & ~fire_nxt[i]) shots_nxt[i] = shots_q[i] - 3'd1;
      end
   end

   always_comb begin
      cooling = '0;
      for (int i = 0; i < N_CH; i++) begin
         cooling[i] = (state_q[i] == ST_COOL);
      end
   end

   assign bus.fire       = fire_q;
   assign bus.cooling    = cooling;
   assign bus.shots_live = shots_q;

endmodule

// File: tb/tb_fire_ctrl_multi.sv
// Bench for fire_ctrl_multi: two instances sharing one stimulus stream.
//   dut_a: CD_FRAMES=3, MAX_SHOTS=7, ONE_PER_TICK=0
//   dut_b: CD_FRAMES=3, MAX_SHOTS=1, ONE_PER_TICK=1
// A tick-level model tracks ticks left in cooldown, a must-release flag and
// in-flight counts; outputs are compared every cycle, plus literal checks.
module tb_fire_ctrl_multi;
   localparam int CD = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       enb, frame_tick;
   logic [3:0] btn, auto_mode, bullet_done;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   int         cool_left [2][4];
   bit         need_rel  [2][4];
   int         shots     [2][4];
   logic [3:0] fire_m    [2];

   logic [3:0]  cmp_f, cmp_c, exp_c;
   logic [11:0] cmp_s, exp_s;
   int          cnt;

   fire_ctrl_multi_if #(.N_CH(4)) bus_a ();
   fire_ctrl_multi_if #(.N_CH(4)) bus_b ();

   assign bus_a.enb = enb;          assign bus_b.enb = enb;
   assign bus_a.frame_tick = frame_tick;  assign bus_b.frame_tick = frame_tick;
   assign bus_a.btn = btn;          assign bus_b.btn = btn;
   assign bus_a.auto_mode = auto_mode;    assign bus_b.auto_mode = auto_mode;
   assign bus_a.bullet_done = bullet_done; assign bus_b.bullet_done = bullet_done;

   fire_ctrl_multi #(.N_CH(4), .CD_W(6), .CD_FRAMES(CD), .MAX_SHOTS(7), .ONE_PER_TICK(0))
      dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   fire_ctrl_multi #(.N_CH(4), .CD_W(6), .CD_FRAMES(CD), .MAX_SHOTS(1), .ONE_PER_TICK(1))
      dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update();
      for (int m = 0; m < 2; m++) begin
         int         maxs;
         bit         one, granted;
         logic [3:0] fn;
         maxs = (m == 0) ? 7 : 1;
         one = (m == 1);
         granted = 1'b0;
         fn = '0;
         if (rst) begin
            for (int i = 0; i < 4; i++) begin
               cool_left[m][i] = 0;
               need_rel[m][i] = 1'b0;
               shots[m][i] = 0;
            end
         end else if (enb) begin
            if (frame_tick) begin
               for (int i = 0; i < 4; i++) begin
                  if (cool_left[m][i] > 0) begin
                     cool_left[m][i]--;
                     if (cool_left[m][i] == 0) need_rel[m][i] = !auto_mode[i] && btn[i];
                  end else if (need_rel[m][i]) begin
                     if (!btn[i]) need_rel[m][i] = 1'b0;
                  end else if (btn[i] && shots[m][i] < maxs && !(one && granted)) begin
                     fn[i] = 1'b1;
                     cool_left[m][i] = CD;
                     granted = 1'b1;
                  end
               end
            end
            for (int i = 0; i < 4; i++) begin
               if (fn[i] && !(bullet_done[i] && shots[m][i] > 0)) shots[m][i]++;
               else if (!fn[i] && bullet_done[i] && shots[m][i] > 0) shots[m][i]--;
            end
         end
         fire_m[m] = fn;
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int m = 0; m < 2; m++) begin
            cmp_f = (m == 0) ? bus_a.fire : bus_b.fire;
            cmp_c = (m == 0) ? bus_a.cooling : bus_b.cooling;
            cmp_s = (m == 0) ? bus_a.shots_live : bus_b.shots_live;
            for (int i = 0; i < 4; i++) begin
               exp_c[i] = (cool_left[m][i] != 0);
               exp_s[3*i +: 3] = 3'(shots[m][i]);
            end
            check($sformatf("model_fire_%0d", m), int'(cmp_f), int'(fire_m[m]));
            check($sformatf("model_cooling_%0d", m), int'(cmp_c), int'(exp_c));
            check($sformatf("model_shots_%0d", m), int'(cmp_s), int'(exp_s));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic tick(input logic [3:0] done_v = 4'b0);
      step();
      step();
      frame_tick = 1'b1;
      bullet_done = done_v;
      step();
      frame_tick = 1'b0;
      bullet_done = 4'b0;
   endtask

   task automatic do_reset();
      btn = '0;
      auto_mode = '0;
      bullet_done = '0;
      enb = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; enb = 1'b1; frame_tick = 1'b0;
      btn = '0; auto_mode = '0; bullet_done = '0;
      step();
      chk_en = 1'b1;
      step();
      rst = 1'b0;
      check("rst_fire", int'({bus_a.fire, bus_b.fire}), 0);
      check("rst_cooling", int'({bus_a.cooling, bus_b.cooling}), 0);
      check("rst_shots", int'(bus_a.shots_live | bus_b.shots_live), 0);

      // auto repeat every CD+1 ticks, in-flight count climbs
      auto_mode = 4'b0001; btn = 4'b0001;
      for (int t = 1; t <= 9; t++) begin
         tick();
         check($sformatf("auto_fire_t%0d", t), int'(bus_a.fire[0]), (t % 4 == 1) ? 1 : 0);
         if (t % 4 == 1) check($sformatf("auto_shots_t%0d", t), int'(bus_a.shots_live[2:0]), t / 4 + 1);
      end
      step();
      check("auto_pulse_width", int'(bus_a.fire[0]), 0);
      for (int k = 0; k < 4; k++) begin
         bullet_done = 4'b0001;
         step();
         bullet_done = 4'b0;
         step();
      end
      check("no_underflow", int'(bus_a.shots_live[2:0]), 0);

      // single shot: one fire while held, release then press again
      do_reset();
      auto_mode = 4'b0000; btn = 4'b0010;
      cnt = 0;
      for (int t = 1; t <= 20; t++) begin
         tick();
         cnt += int'(bus_a.fire[1]);
      end
      check("single_held_count", cnt, 1);
      btn = 4'b0000;
      tick();
      check("single_release_tick", int'(bus_a.fire[1]), 0);
      btn = 4'b0010;
      tick();
      check("single_refire", int'(bus_a.fire[1]), 1);

      // shot cap of one: blocked until the bullet dies
      do_reset();
      auto_mode = 4'b0100; btn = 4'b0100;
      cnt = 0;
      for (int t = 1; t <= 6; t++) begin
         tick();
         cnt += int'(bus_b.fire[2]);
      end
      check("cap_count", cnt, 1);
      bullet_done = 4'b0100;
      step();
      bullet_done = 4'b0;
      check("cap_done_shots", int'(bus_b.shots_live[8:6]), 0);
      tick();
      check("cap_refire", int'(bus_b.fire[2]), 1);
      check("cap_refire_shots", int'(bus_b.shots_live[8:6]), 1);

      // arbitration: lowest index per tick vs all at once
      do_reset();
      btn = 4'b1110;
      tick();
      check("arb_all_t1", int'(bus_a.fire), 4'b1110);
      check("arb_one_t1", int'(bus_b.fire), 4'b0010);
      tick();
      check("arb_one_t2", int'(bus_b.fire), 4'b0100);
      tick();
      check("arb_one_t3", int'(bus_b.fire), 4'b1000);

      // enb low freezes cooldown and counts
      do_reset();
      auto_mode = 4'b0001; btn = 4'b0001;
      tick();
      check("frz_fire", int'(bus_a.fire[0]), 1);
      enb = 1'b0;
      for (int t = 1; t <= 10; t++) begin
         tick();
         check($sformatf("frz_cool_t%0d", t), int'({bus_a.cooling[0], bus_a.fire[0]}), 2);
      end
      bullet_done = 4'b0001;
      step();
      bullet_done = 4'b0;
      check("frz_done_ignored", int'(bus_a.shots_live[2:0]), 1);
      enb = 1'b1;
      tick();
      tick();
      check("frz_cool_after2", int'(bus_a.cooling[0]), 1);
      tick();
      check("frz_idle_after3", int'({bus_a.cooling[0], bus_a.fire[0]}), 0);
      tick(4'b0001);
      check("fire_and_done_fire", int'(bus_a.fire[0]), 1);
      check("fire_and_done_shots", int'(bus_a.shots_live[2:0]), 1);

      // reset in the middle of a cooldown
      do_reset();
      auto_mode = 4'b0001; btn = 4'b0001;
      tick();
      tick();
      check("mid_rst_pre", int'({bus_a.cooling[0], bus_a.shots_live[2:0]}), 4'b1001);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_clear", int'({bus_a.fire[0], bus_a.cooling[0], bus_a.shots_live[2:0]}), 0);
      tick();
      check("mid_rst_refire", int'(bus_a.fire[0]), 1);

      step();
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
